hazard_unit: RTL and testbench

//  Parametrised hazard detection / forwarding controller for the 5-stage pipeline.

---
 rtl/cpu_pipe_pkg.sv | 38 +++
 rtl/hazard_unit_if.sv | 37 +++
 rtl/hazard_unit_scoreboard.sv | 32 +++
 rtl/hazard_unit.sv | 118 +++++++++++
 tb/tb_hazard_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding controller.
package cpu_pipe_pkg;

  localparam int unsigned HAZ_STAGES   = 3;
  localparam int unsigned HAZ_ADDR_MAX = 8;

  localparam int unsigned ST_EX  = 0;
  localparam int unsigned ST_MEM = 1;
  localparam int unsigned ST_WB  = 2;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // Register addresses are zero-extended into a fixed-width field so the
  // entry type stays independent of the register-file size.
  typedef logic [HAZ_ADDR_MAX-1:0] haz_addr_t;

  typedef struct packed {
    logic      valid;
    logic      wr;
    haz_addr_t waddr;
    logic      load;
    haz_addr_t r1;
    haz_addr_t r2;
    logic      r1_used;
    logic      r2_used;
  } haz_entry_t;

  // True when a used source register is written by an in-flight stage.
  function automatic logic haz_match(input haz_addr_t src, input logic used,
                                     input haz_entry_t st);
    return used & st.valid & st.wr & (st.waddr == src);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage request and hazard-control response bundle.
interface hazard_unit_if #(
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned CNT_BITS      = 16
);
  logic                     id_valid;
  logic [REG_ADDR_BITS-1:0] id_r1_addr;
  logic [REG_ADDR_BITS-1:0] id_r2_addr;
  logic                     id_r1_used;
  logic                     id_r2_used;
  logic                     id_rw_;
  logic [REG_ADDR_BITS-1:0] id_waddr;
  logic                     id_sel_mem;
  logic                     ex_redirect;
  logic                     stall_if;
  logic                     stall_id;
  logic                     bubble_ex;
  logic                     flush_id;
  logic [1:0]               fwd_sel_1;
  logic [1:0]               fwd_sel_2;
  logic [CNT_BITS-1:0]      stall_cnt;
  logic [CNT_BITS-1:0]      flush_cnt;

  modport master (
    output id_valid, id_r1_addr, id_r2_addr, id_r1_used, id_r2_used,
           id_rw_, id_waddr, id_sel_mem, ex_redirect,
    input  stall_if, stall_id, bubble_ex, flush_id, fwd_sel_1, fwd_sel_2,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_r1_addr, id_r2_addr, id_r1_used, id_r2_used,
           id_rw_, id_waddr, id_sel_mem, ex_redirect,
    output stall_if, stall_id, bubble_ex, flush_id, fwd_sel_1, fwd_sel_2,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit_scoreboard.sv
// Shadow EX/MEM/WB register-writer entries, advancing one stage per clock.
module haz_scoreboard
  import cpu_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  haz_entry_t id_entry,
  input  logic       take_id,
  output haz_entry_t ex_entry,
  output haz_entry_t mem_entry,
  output haz_entry_t wb_entry
);

  haz_entry_t [HAZ_STAGES-1:0] stg_q;

  // EX takes the ID entry or a bubble; older stages shift down.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stg_q <= '0;
    end else begin
      stg_q[ST_EX] <= take_id ? id_entry : '0;
      for (int i = 1; i < int'(HAZ_STAGES); i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign ex_entry  = stg_q[ST_EX];
  assign mem_entry = stg_q[ST_MEM];
  assign wb_entry  = stg_q[ST_WB];

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection, EX forwarding select, branch flush and perf counters.
// Build option: HAZARD_FWD_EN enables EX forwarding (only load-use stalls);
// without it every RAW dependency stalls until the writer has retired.
module hazard_unit
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic          clk,
  input  logic          rst_,
  hazard_unit_if.slave  hz
);

  haz_entry_t          id_entry;
  haz_entry_t          ex_entry;
  haz_entry_t          mem_entry;
  haz_entry_t          wb_entry;
  logic                raw_hazard;
  logic                stall_c;
  logic                flush_c;
  logic                bubble_c;
  logic                take_id;
  fwd_sel_t            fwd1_c;
  fwd_sel_t            fwd2_c;
  logic [CNT_BITS-1:0] stall_cnt_q;
  logic [CNT_BITS-1:0] flush_cnt_q;
  logic                unused_sb;

  // Either ID source is written by the given stage entry.
  function automatic logic id_hits(input haz_entry_t id, input haz_entry_t st);
    return haz_match(id.r1, id.r1_used, st) | haz_match(id.r2, id.r2_used, st);
  endfunction

  // Pack the ID instruction; writes to r0 never create a dependency.
  always_comb begin
    id_entry         = '0;
    id_entry.valid   = hz.id_valid;
    id_entry.wr      = ~hz.id_rw_ & (hz.id_waddr != REG_ADDR_BITS'(0));
    id_entry.waddr   = HAZ_ADDR_MAX'(hz.id_waddr);
    id_entry.load    = hz.id_sel_mem;
    id_entry.r1      = HAZ_ADDR_MAX'(hz.id_r1_addr);
    id_entry.r2      = HAZ_ADDR_MAX'(hz.id_r2_addr);
    id_entry.r1_used = hz.id_r1_used;
    id_entry.r2_used = hz.id_r2_used;
  end

  // Stall/flush decision; redirect overrides any stall in the same cycle.
  always_comb begin
    raw_hazard = 1'b0;
`ifdef HAZARD_FWD_EN
    raw_hazard = id_hits(id_entry, ex_entry) & ex_entry.load;
`else
    raw_hazard = id_hits(id_entry, ex_entry) | id_hits(id_entry, mem_entry) |
                 id_hits(id_entry, wb_entry);
`endif
    stall_c  = rst_ & hz.id_valid & raw_hazard & ~hz.ex_redirect;
    flush_c  = rst_ & hz.ex_redirect;
    bubble_c = stall_c | flush_c;
    take_id  = hz.id_valid & ~bubble_c;
  end

`ifdef HAZARD_FWD_EN
  // Nearest producer wins: MEM result before WB data before regfile.
  function automatic fwd_sel_t fwd_pick(input haz_addr_t src, input logic used,
                                        input haz_entry_t mem, input haz_entry_t wb);
    if (haz_match(src, used, mem)) return FWD_MEM;
    if (haz_match(src, used, wb))  return FWD_WB;
    return FWD_RF;
  endfunction
`endif

  // Operand source selects for the instruction now in EX.
  always_comb begin
    fwd1_c = FWD_RF;
    fwd2_c = FWD_RF;
`ifdef HAZARD_FWD_EN
    if (rst_) begin
      fwd1_c = fwd_pick(ex_entry.r1, ex_entry.r1_used, mem_entry, wb_entry);
      fwd2_c = fwd_pick(ex_entry.r2, ex_entry.r2_used, mem_entry, wb_entry);
    end
`endif
  end

  // Saturating stall and flush cycle counters.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
      if (flush_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_BITS'(1);
    end
  end

  haz_scoreboard u_sb (
    .clk       (clk),
    .rst_      (rst_),
    .id_entry  (id_entry),
    .take_id   (take_id),
    .ex_entry  (ex_entry),
    .mem_entry (mem_entry),
    .wb_entry  (wb_entry)
  );

  // Not every tracked field is consulted in every build.
  assign unused_sb = ^{ex_entry, mem_entry, wb_entry};

  assign hz.stall_if  = stall_c;
  assign hz.stall_id  = stall_c;
  assign hz.bubble_ex = bubble_c;
  assign hz.flush_id  = flush_c;
  assign hz.fwd_sel_1 = fwd1_c;
  assign hz.fwd_sel_2 = fwd2_c;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver queues expected per-cycle outputs,
// negedge monitor pops and compares. Follows HAZARD_FWD_EN like the DUT.
module tb_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CMAX = '1;
`ifdef HAZARD_FWD_EN
  localparam int PER = 1;
`else
  localparam int PER = 3;
`endif

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_ADDR_BITS(AW), .CNT_BITS(CW)) bus ();

  hazard_unit #(.REG_ADDR_BITS(AW), .CNT_BITS(CW)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .hz   (bus)
  );

  typedef struct {
    string          nm;
    logic           st;
    logic           fl;
    logic           bb;
    logic [1:0]     f1;
    logic [1:0]     f2;
    bit             fc;
    logic [CW-1:0]  sc;
    logic [CW-1:0]  fcn;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_sc = '0;
  logic [CW-1:0] m_fc = '0;

  task automatic chk(input string nm, input string sig,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d expected=%0d", nm, sig, act, exp);
    end
  endtask

  // One cycle of ID stimulus; es = expected stall, f1/f2 = expected selects.
  task automatic step(input string nm, input int v, input int a1, input int a2,
                      input int u1, input int u2, input int wr, input int wa,
                      input int ld, input int rd, input int es,
                      input int f1, input int f2, input bit fc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.id_valid    = 1'(v);
    bus.id_r1_addr  = AW'(a1);
    bus.id_r2_addr  = AW'(a2);
    bus.id_r1_used  = 1'(u1);
    bus.id_r2_used  = 1'(u2);
    bus.id_rw_      = ~1'(wr);
    bus.id_waddr    = AW'(wa);
    bus.id_sel_mem  = 1'(ld);
    bus.ex_redirect = 1'(rd);
    e.nm  = nm;
    e.st  = 1'(es);
    e.fl  = 1'(rd);
    e.bb  = 1'(es) | 1'(rd);
    e.f1  = 2'(f1);
    e.f2  = 2'(f2);
    e.fc  = fc;
    e.sc  = m_sc;
    e.fcn = m_fc;
    q.push_back(e);
    if (es != 0 && m_sc != CMAX) m_sc = m_sc + 1'b1;
    if (rd != 0 && m_fc != CMAX) m_fc = m_fc + 1'b1;
  endtask

  task automatic idle(input int n, input bit fc);
    repeat (n) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fc);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, "stall_if",  32'(bus.stall_if),  32'(0));
    chk(nm, "stall_id",  32'(bus.stall_id),  32'(0));
    chk(nm, "bubble_ex", 32'(bus.bubble_ex), 32'(0));
    chk(nm, "flush_id",  32'(bus.flush_id),  32'(0));
    chk(nm, "fwd_sel_1", 32'(bus.fwd_sel_1), 32'(0));
    chk(nm, "fwd_sel_2", 32'(bus.fwd_sel_2), 32'(0));
    chk(nm, "stall_cnt", 32'(bus.stall_cnt), 32'(0));
    chk(nm, "flush_cnt", 32'(bus.flush_cnt), 32'(0));
  endtask

  // Monitor: compare the cycle's outputs away from the active edge.
  always @(negedge clk) begin
    if (rst_ && q.size() > 0) begin
      cur = q.pop_front();
      chk(cur.nm, "stall_if",  32'(bus.stall_if),  32'(cur.st));
      chk(cur.nm, "stall_id",  32'(bus.stall_id),  32'(cur.st));
      chk(cur.nm, "bubble_ex", 32'(bus.bubble_ex), 32'(cur.bb));
      chk(cur.nm, "flush_id",  32'(bus.flush_id),  32'(cur.fl));
      if (cur.fc) begin
        chk(cur.nm, "fwd_sel_1", 32'(bus.fwd_sel_1), 32'(cur.f1));
        chk(cur.nm, "fwd_sel_2", 32'(bus.fwd_sel_2), 32'(cur.f2));
      end
      chk(cur.nm, "stall_cnt", 32'(bus.stall_cnt), 32'(cur.sc));
      chk(cur.nm, "flush_cnt", 32'(bus.flush_cnt), 32'(cur.fcn));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_valid = 1'b0; bus.id_r1_addr = '0; bus.id_r2_addr = '0;
    bus.id_r1_used = 1'b0; bus.id_r2_used = 1'b0; bus.id_rw_ = 1'b1;
    bus.id_waddr = '0; bus.id_sel_mem = 1'b0; bus.ex_redirect = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;

    //  nm                v a1 a2 u1 u2 wr wa ld rd es f1 f2 fc
    step("rst_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Load-use and redirect together: redirect wins.
    step("t4_lw",         1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 1);
    step("t4_ldu_redir",  1, 7, 1, 1, 1, 1, 8, 0, 1, 0, 0, 0, 1);
    step("t4_after",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3, 1);

`ifdef HAZARD_FWD_EN
    step("t1_add_r3",     1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 1);
    step("t1_add_r4",     1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 0, 0, 1);
    step("t1_fwd_mem",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(3, 1);
    step("t2_add_r3",     1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 1);
    step("t2_nop",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("t2_sub_r6",     1, 3, 3, 1, 1, 1, 6, 0, 0, 0, 0, 0, 1);
    step("t2_fwd_wb",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 1);
    idle(3, 1);
    step("t3_lw_r7",      1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 1);
    step("t3_ldu_stall",  1, 7, 1, 1, 1, 1, 8, 0, 0, 1, 0, 0, 1);
    step("t3_ldu_go",     1, 7, 1, 1, 1, 1, 8, 0, 0, 0, 0, 0, 1);
    step("t3_fwd_wb",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
    idle(3, 1);
`else
    step("t1_add_r3",     1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 1);
    step("t1_use_ex",     1, 3, 5, 1, 1, 1, 4, 0, 0, 1, 0, 0, 1);
    step("t1_use_mem",    1, 3, 5, 1, 1, 1, 4, 0, 0, 1, 0, 0, 1);
    step("t1_use_wb",     1, 3, 5, 1, 1, 1, 4, 0, 0, 1, 0, 0, 1);
    step("t1_use_go",     1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 0, 0, 1);
    idle(3, 1);
    step("t2_add_r3",     1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 1);
    step("t2_nop",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("t2_sub_mem",    1, 3, 3, 1, 1, 1, 6, 0, 0, 1, 0, 0, 1);
    step("t2_sub_wb",     1, 3, 3, 1, 1, 1, 6, 0, 0, 1, 0, 0, 1);
    step("t2_sub_go",     1, 3, 3, 1, 1, 1, 6, 0, 0, 0, 0, 0, 1);
    idle(3, 1);
    step("t3_lw_r7",      1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 1);
    step("t3_use_ex",     1, 7, 1, 1, 1, 1, 8, 0, 0, 1, 0, 0, 1);
    step("t3_use_mem",    1, 7, 1, 1, 1, 1, 8, 0, 0, 1, 0, 0, 1);
    step("t3_use_wb",     1, 7, 1, 1, 1, 1, 8, 0, 0, 1, 0, 0, 1);
    step("t3_use_go",     1, 7, 1, 1, 1, 1, 8, 0, 0, 0, 0, 0, 1);
    idle(3, 1);
`endif

    // r0 destination never creates a dependency.
    step("t5_add_r0",     1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    step("t5_use_r0",     1, 0, 0, 1, 1, 1, 9, 0, 0, 0, 0, 0, 1);
    step("t5_fwd_r0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3, 1);

    // Asynchronous reset in the middle of a load-use stall.
    step("t6_lw",         1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 1);
    step("t6_ldu",        1, 7, 1, 1, 1, 1, 8, 0, 0, 1, 0, 0, 1);
    @(negedge clk);
    #1;
    rst_ = 1'b0;
    bus.ex_redirect = 1'b1;
    #1;
    chk_all_zero("t6_in_reset");
    bus.ex_redirect = 1'b0;
    bus.id_valid = 1'b0;
    m_sc = '0;
    m_fc = '0;
    #1;
    rst_ = 1'b1;
    step("t6_post_rst",   1, 7, 1, 1, 1, 1, 8, 0, 0, 0, 0, 0, 1);
    idle(3, 1);

    // Drive more than 2^CW stall cycles; counter must stick at all-ones.
    for (int it = 0; it < ((1 << CW) + 5 + PER - 1) / PER; it++) begin
      step("sat_lw",      1, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0);
      repeat (PER)
        step("sat_stall", 1, 7, 1, 1, 1, 1, 8, 0, 0, 1, 0, 0, 0);
      step("sat_go",      1, 7, 1, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0);
    end
    idle(3, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat", "stall_cnt", 32'(bus.stall_cnt), 32'(CMAX));
    chk("drain", "queue_left", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
